// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// datapath select codes and the opcode-decoder result record.
package multicycle_ctrl_pkg;

  localparam int OP_W = 6;
  localparam int ST_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  typedef enum logic [ST_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_OR    = 3'b011,
    ALU_AND   = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_LUI   = 3'b110
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_MEM,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_IMM,
    CLS_ILLEGAL
  } icls_t;

  typedef struct packed {
    icls_t   cls;
    logic    is_store;
    logic    is_bne;
    logic    ext_ctr;
    alu_op_t alu_op;
    logic    illegal;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_opcode_dec.sv
// Combinational opcode classifier: instruction class, immediate extension mode
// and ALU operation for the I-type execute state.
module ctrl_opcode_dec
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW = OP_W
) (
  input  logic [OPW-1:0] opcode,
  output dec_t           dec
);

  always_comb begin
    dec = '{cls: CLS_ILLEGAL, is_store: 1'b0, is_bne: 1'b0,
            ext_ctr: 1'b1, alu_op: ALU_ADD, illegal: 1'b1};
    case (opcode)
      OP_RTYPE: begin dec.cls = CLS_R;      dec.illegal = 1'b0; end
      OP_LW:    begin dec.cls = CLS_MEM;    dec.illegal = 1'b0; end
      OP_SW:    begin dec.cls = CLS_MEM;    dec.illegal = 1'b0; dec.is_store = 1'b1; end
      OP_BEQ:   begin dec.cls = CLS_BRANCH; dec.illegal = 1'b0; end
      OP_BNE:   begin dec.cls = CLS_BRANCH; dec.illegal = 1'b0; dec.is_bne = 1'b1; end
      OP_J:     begin dec.cls = CLS_JUMP;   dec.illegal = 1'b0; end
      OP_ADDI, OP_ADDIU: begin
        dec.cls = CLS_IMM; dec.illegal = 1'b0;
      end
      OP_SLTI: begin
        dec.cls = CLS_IMM; dec.illegal = 1'b0; dec.alu_op = ALU_SLT;
      end
      // Logical immediates and lui take the raw 16-bit field
      OP_ANDI: begin
        dec.cls = CLS_IMM; dec.illegal = 1'b0; dec.alu_op = ALU_AND; dec.ext_ctr = 1'b0;
      end
      OP_ORI: begin
        dec.cls = CLS_IMM; dec.illegal = 1'b0; dec.alu_op = ALU_OR; dec.ext_ctr = 1'b0;
      end
      OP_LUI: begin
        dec.cls = CLS_IMM; dec.illegal = 1'b0; dec.alu_op = ALU_LUI; dec.ext_ctr = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback and
// drives every datapath select and write enable from the current state.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           i_or_d,
  output logic           ir_we,
  output logic           pc_we,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [2:0]     alu_op,
  output logic           ext_ctr,
  output logic           reg_we,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           illegal_op,
  output logic [STW-1:0] state_o
);

  state_t state;
  dec_t   dec;

  // funct is consumed by the ALU control, not by this FSM
  logic unused_funct;
  assign unused_funct = ^funct;

  ctrl_opcode_dec #(.OPW(OPW)) u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (dec.cls)
            CLS_R:      state <= S_EXEC_R;
            CLS_MEM:    state <= S_MEM_ADDR;
            CLS_BRANCH: state <= S_BRANCH;
            CLS_JUMP:   state <= S_JUMP;
            CLS_IMM:    state <= S_EXEC_I;
            default:    state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: state <= dec.is_store ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) state <= S_WB_MEM;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_EXEC_R:   state <= S_WB_R;
        S_EXEC_I:   state <= S_WB_I;
        S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state <= S_FETCH;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so an async reset drops mem_req in the same cycle
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    ext_ctr    = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        ext_ctr    = 1'b1;
        illegal_op = dec.illegal;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_ctr   = 1'b1;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_WB_MEM: begin
        reg_we     = mem_ready;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_WB_R: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = dec.alu_op;
        ext_ctr   = dec.ext_ctr;
      end
      S_WB_I: reg_we = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        ext_ctr   = 1'b1;
        pc_src    = PC_ALUOUT;
        pc_we     = zero ^ dec.is_bne;
      end
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = STW'(state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: the stimulus pushes the hand-derived per-cycle
// output vector into a queue, a negedge monitor pops and compares it.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, i_or_d, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       a;
    logic [1:0] b;
    logic [2:0] op;
    logic       ext, reg_we, reg_dst, m2r, ill;
  } obs_t;

  localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_BEQ = 6'h04, T_BNE = 6'h05;
  localparam logic [5:0] T_ADDI = 6'h08, T_ORI = 6'h0D, T_LW = 6'h23, T_SW = 6'h2B;
  localparam logic [5:0] T_ILL = 6'h3F;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, i_or_d, ir_we, pc_we, alu_src_a, ext_ctr;
  logic       reg_we, reg_dst, mem_to_reg, illegal_op;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  obs_t       obs;

  obs_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_ctr(ext_ctr), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign obs = {state_o, mem_req, mem_we, i_or_d, ir_we, pc_we, pc_src, alu_src_a,
                alu_src_b, alu_op, ext_ctr, reg_we, reg_dst, mem_to_reg, illegal_op};

  function automatic obs_t z0(input logic [3:0] st);
    obs_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic obs_t e_fetch(input logic rdy);
    obs_t e = z0(S_FETCH);
    e.mem_req = 1'b1; e.b = 2'b01; e.ir_we = rdy; e.pc_we = rdy;
    return e;
  endfunction

  function automatic obs_t e_decode(input logic ill);
    obs_t e = z0(S_DECODE);
    e.b = 2'b11; e.ext = 1'b1; e.ill = ill;
    return e;
  endfunction

  function automatic obs_t e_maddr();
    obs_t e = z0(S_MEM_ADDR);
    e.a = 1'b1; e.b = 2'b10; e.ext = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_mrd();
    obs_t e = z0(S_MEM_RD);
    e.mem_req = 1'b1; e.i_or_d = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_wbmem();
    obs_t e = z0(S_WB_MEM);
    e.reg_we = 1'b1; e.m2r = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_mwr();
    obs_t e = z0(S_MEM_WR);
    e.mem_req = 1'b1; e.mem_we = 1'b1; e.i_or_d = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_execr();
    obs_t e = z0(S_EXEC_R);
    e.a = 1'b1; e.op = 3'b010;
    return e;
  endfunction

  function automatic obs_t e_wbr();
    obs_t e = z0(S_WB_R);
    e.reg_we = 1'b1; e.reg_dst = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_execi(input logic [2:0] op, input logic ext);
    obs_t e = z0(S_EXEC_I);
    e.a = 1'b1; e.b = 2'b10; e.op = op; e.ext = ext;
    return e;
  endfunction

  function automatic obs_t e_wbi();
    obs_t e = z0(S_WB_I);
    e.reg_we = 1'b1;
    return e;
  endfunction

  function automatic obs_t e_branch(input logic take);
    obs_t e = z0(S_BRANCH);
    e.a = 1'b1; e.op = 3'b001; e.pc_src = 2'b01; e.ext = 1'b1; e.pc_we = take;
    return e;
  endfunction

  function automatic obs_t e_jump();
    obs_t e = z0(S_JUMP);
    e.pc_src = 2'b10; e.pc_we = 1'b1;
    return e;
  endfunction

  // One clock cycle: inputs change just after the edge, expectation queued for this cycle
  task automatic step(input obs_t e, input string nm, input logic rst,
                      input logic [5:0] op, input logic z, input logic rdy);
    @(posedge clk);
    #1;
    reset = rst; opcode = op; zero = z; mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s: got %h (state %0d) want %h (state %0d)", n, obs, obs.st, e, e.st);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // reset and release
    step(z0(S_IDLE), "reset0", 1'b1, T_R, 1'b0, 1'b0);
    step(z0(S_IDLE), "reset1", 1'b1, T_R, 1'b0, 1'b1);
    step(z0(S_IDLE), "release", 1'b0, T_LW, 1'b0, 1'b1);

    // lw, zero wait: 5 cycles
    step(e_fetch(1'b1), "lw_fetch", 1'b0, T_LW, 1'b0, 1'b1);
    step(e_decode(1'b0), "lw_decode", 1'b0, T_LW, 1'b0, 1'b1);
    step(e_maddr(), "lw_maddr", 1'b0, T_LW, 1'b0, 1'b1);
    step(e_mrd(), "lw_mrd", 1'b0, T_LW, 1'b0, 1'b1);
    step(e_wbmem(), "lw_wb", 1'b0, T_LW, 1'b0, 1'b1);

    // sw: 4 cycles
    step(e_fetch(1'b1), "sw_fetch", 1'b0, T_SW, 1'b0, 1'b1);
    step(e_decode(1'b0), "sw_decode", 1'b0, T_SW, 1'b0, 1'b1);
    step(e_maddr(), "sw_maddr", 1'b0, T_SW, 1'b0, 1'b1);
    step(e_mwr(), "sw_mwr", 1'b0, T_SW, 1'b0, 1'b1);

    // R-type: 4 cycles
    step(e_fetch(1'b1), "r_fetch", 1'b0, T_R, 1'b0, 1'b1);
    step(e_decode(1'b0), "r_decode", 1'b0, T_R, 1'b0, 1'b1);
    step(e_execr(), "r_exec", 1'b0, T_R, 1'b0, 1'b1);
    step(e_wbr(), "r_wb", 1'b0, T_R, 1'b0, 1'b1);

    // ori zero-extends, addi sign-extends
    step(e_fetch(1'b1), "ori_fetch", 1'b0, T_ORI, 1'b0, 1'b1);
    step(e_decode(1'b0), "ori_decode", 1'b0, T_ORI, 1'b0, 1'b1);
    step(e_execi(3'b011, 1'b0), "ori_exec", 1'b0, T_ORI, 1'b0, 1'b1);
    step(e_wbi(), "ori_wb", 1'b0, T_ORI, 1'b0, 1'b1);
    step(e_fetch(1'b1), "addi_fetch", 1'b0, T_ADDI, 1'b0, 1'b1);
    step(e_decode(1'b0), "addi_decode", 1'b0, T_ADDI, 1'b0, 1'b1);
    step(e_execi(3'b000, 1'b1), "addi_exec", 1'b0, T_ADDI, 1'b0, 1'b1);
    step(e_wbi(), "addi_wb", 1'b0, T_ADDI, 1'b0, 1'b1);

    // branches: beq takes on zero, bne on ~zero
    step(e_fetch(1'b1), "beq1_fetch", 1'b0, T_BEQ, 1'b1, 1'b1);
    step(e_decode(1'b0), "beq1_decode", 1'b0, T_BEQ, 1'b1, 1'b1);
    step(e_branch(1'b1), "beq_z1", 1'b0, T_BEQ, 1'b1, 1'b1);
    step(e_fetch(1'b1), "beq0_fetch", 1'b0, T_BEQ, 1'b0, 1'b1);
    step(e_decode(1'b0), "beq0_decode", 1'b0, T_BEQ, 1'b0, 1'b1);
    step(e_branch(1'b0), "beq_z0", 1'b0, T_BEQ, 1'b0, 1'b1);
    step(e_fetch(1'b1), "bne1_fetch", 1'b0, T_BNE, 1'b1, 1'b1);
    step(e_decode(1'b0), "bne1_decode", 1'b0, T_BNE, 1'b1, 1'b1);
    step(e_branch(1'b0), "bne_z1", 1'b0, T_BNE, 1'b1, 1'b1);
    step(e_fetch(1'b1), "bne0_fetch", 1'b0, T_BNE, 1'b0, 1'b1);
    step(e_decode(1'b0), "bne0_decode", 1'b0, T_BNE, 1'b0, 1'b1);
    step(e_branch(1'b1), "bne_z0", 1'b0, T_BNE, 1'b0, 1'b1);

    // jump: 3 cycles
    step(e_fetch(1'b1), "j_fetch", 1'b0, T_J, 1'b0, 1'b1);
    step(e_decode(1'b0), "j_decode", 1'b0, T_J, 1'b0, 1'b1);
    step(e_jump(), "j_jump", 1'b0, T_J, 1'b0, 1'b1);

    // fetch waits 3 cycles: request held, IR/PC written only on the 4th
    step(e_fetch(1'b0), "fw_wait0", 1'b0, T_R, 1'b0, 1'b0);
    step(e_fetch(1'b0), "fw_wait1", 1'b0, T_R, 1'b0, 1'b0);
    step(e_fetch(1'b0), "fw_wait2", 1'b0, T_R, 1'b0, 1'b0);
    step(e_fetch(1'b1), "fw_done", 1'b0, T_R, 1'b0, 1'b1);
    step(e_decode(1'b0), "fw_decode", 1'b0, T_R, 1'b0, 1'b1);
    step(e_execr(), "fw_exec", 1'b0, T_R, 1'b0, 1'b1);
    step(e_wbr(), "fw_wb", 1'b0, T_R, 1'b0, 1'b1);

    // illegal opcode: one-cycle pulse, straight back to fetch
    step(e_fetch(1'b1), "ill_fetch", 1'b0, T_ILL, 1'b0, 1'b1);
    step(e_decode(1'b1), "ill_decode", 1'b0, T_ILL, 1'b0, 1'b1);
    step(e_fetch(1'b0), "ill_refetch", 1'b0, T_ILL, 1'b0, 1'b0);

    // lw with two read wait cycles
    step(e_fetch(1'b1), "lww_fetch", 1'b0, T_LW, 1'b0, 1'b1);
    step(e_decode(1'b0), "lww_decode", 1'b0, T_LW, 1'b0, 1'b1);
    step(e_maddr(), "lww_maddr", 1'b0, T_LW, 1'b0, 1'b0);
    step(e_mrd(), "lww_mrd0", 1'b0, T_LW, 1'b0, 1'b0);
    step(e_mrd(), "lww_mrd1", 1'b0, T_LW, 1'b0, 1'b0);
    step(e_mrd(), "lww_mrd2", 1'b0, T_LW, 1'b0, 1'b1);
    step(e_wbmem(), "lww_wb", 1'b0, T_LW, 1'b0, 1'b1);

    // async reset in the middle of a pending read
    step(e_fetch(1'b1), "rst_fetch", 1'b0, T_LW, 1'b0, 1'b1);
    step(e_decode(1'b0), "rst_decode", 1'b0, T_LW, 1'b0, 1'b1);
    step(e_maddr(), "rst_maddr", 1'b0, T_LW, 1'b0, 1'b0);
    step(e_mrd(), "rst_mrd", 1'b0, T_LW, 1'b0, 1'b0);
    step(z0(S_IDLE), "rst_mid", 1'b1, T_LW, 1'b0, 1'b0);
    step(z0(S_IDLE), "rst_hold", 1'b1, T_LW, 1'b0, 1'b1);
    step(z0(S_IDLE), "rst_rel", 1'b0, T_LW, 1'b0, 1'b1);
    step(e_fetch(1'b1), "rst_fetch2", 1'b0, T_LW, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
